// File: rtl/cam_insert_ctrl_pkg.sv
// cam_insert_ctrl_pkg
//   Shared definitions for the CAM insert/delete front-end.
//   - CAM_ST_*: response status codes returned on resp_status.
//   - state_t : 3-bit controller state encoding.
package cam_insert_ctrl_pkg;

  localparam logic [1:0] CAM_ST_OK       = 2'd0;
  localparam logic [1:0] CAM_ST_EXISTS   = 2'd1;
  localparam logic [1:0] CAM_ST_FULL     = 2'd2;
  localparam logic [1:0] CAM_ST_NOTFOUND = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_DECIDE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/cam_insert_ctrl_priority_encoder.sv
// priority_encoder
//   Combinational priority encoder.
//   Ports:
//     input_unencoded  in   WIDTH          request vector
//     output_valid     out  1              any bit set
//     output_encoded   out  clog2(WIDTH)   index of winning bit (0 when none set)
//   LSB_PRIORITY "HIGH" makes the lowest set index win, otherwise the highest.
module priority_encoder #(
  parameter int WIDTH        = 4,
  parameter     LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded
);

  always_comb begin
    output_valid   = |input_unencoded;
    output_encoded = '0;
    if (LSB_PRIORITY == "HIGH") begin
      // Scan downwards so the lowest set bit is the last (winning) assignment.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (input_unencoded[i]) output_encoded = i[$clog2(WIDTH)-1:0];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (input_unencoded[i]) output_encoded = i[$clog2(WIDTH)-1:0];
      end
    end
  end

endmodule

// File: rtl/cam_insert_ctrl.sv
// cam_insert_ctrl
//   Insert/delete request front-end for the block-RAM CAM. A request is looked up on
//   the CAM compare port; inserts allocate the lowest free entry, deletes target the
//   matching entry. The CAM write port is driven for confirmed writes and a status
//   (OK / EXISTS / FULL / NOTFOUND) plus address is returned on the response channel.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     req_data/req_delete/req_valid/req_ready      request channel
//     resp_addr/resp_status/resp_valid/resp_ready  response channel
//     entry_count                       number of occupied entries (0..N)
//     cam_write_addr/data/delete/enable CAM write port (enable is a 1-cycle strobe)
//     cam_write_busy                    CAM busy (init and writes)
//     cam_compare_data                  CAM search key
//     cam_match/cam_match_addr          CAM search result
module cam_insert_ctrl
  import cam_insert_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int CMP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  req_delete,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [1:0]            resp_status,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int N     = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int CNT_W = $clog2(CMP_LATENCY + 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cmp_data_q, cmp_data_d;
  logic                  del_q, del_d;
  logic [CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic                  match_q, match_d;
  logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_del_q, wr_del_d;
  logic                  wait_first_q, wait_first_d;
  logic [N-1:0]          bitmap_q, bitmap_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
  logic [1:0]            resp_status_q, resp_status_d;

  logic                  free_valid;
  logic [ADDR_WIDTH-1:0] free_addr;

  // Lowest clear occupancy bit is the next allocation; no valid bit means full.
  priority_encoder #(
    .WIDTH        (N),
    .LSB_PRIORITY ("HIGH")
  ) u_alloc_enc (
    .input_unencoded (~bitmap_q),
    .output_valid    (free_valid),
    .output_encoded  (free_addr)
  );

  assign resp_valid       = (state_q == ST_RESP);
  assign req_ready        = (state_q == ST_IDLE) & ~cam_write_busy & ~resp_valid;
  assign cam_write_enable = (state_q == ST_ISSUE);
  assign resp_addr        = resp_addr_q;
  assign resp_status      = resp_status_q;
  assign entry_count      = count_q;
  assign cam_write_addr   = wr_addr_q;
  assign cam_write_data   = wr_data_q;
  assign cam_write_delete = wr_del_q;
  assign cam_compare_data = cmp_data_q;

  always_comb begin
    state_d       = state_q;
    cmp_data_d    = cmp_data_q;
    del_d         = del_q;
    lat_cnt_d     = lat_cnt_q;
    match_d       = match_q;
    match_addr_d  = match_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_del_d      = wr_del_q;
    wait_first_d  = wait_first_q;
    bitmap_d      = bitmap_q;
    count_d       = count_q;
    resp_addr_d   = resp_addr_q;
    resp_status_d = resp_status_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          cmp_data_d = req_data;
          del_d      = req_delete;
          lat_cnt_d  = '0;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // The CAM result becomes valid CMP_LATENCY cycles after the key changes;
        // it is sampled one cycle later still so the registered CAM output is settled.
        if (lat_cnt_q == CNT_W'(CMP_LATENCY)) begin
          match_d      = cam_match;
          match_addr_d = cam_match_addr;
          state_d      = ST_DECIDE;
        end else begin
          lat_cnt_d = lat_cnt_q + CNT_W'(1);
        end
      end
      ST_DECIDE: begin
        if (!del_q) begin
          if (match_q) begin
            resp_status_d = CAM_ST_EXISTS;
            resp_addr_d   = match_addr_q;
            state_d       = ST_RESP;
          end else if (!free_valid) begin
            resp_status_d = CAM_ST_FULL;
            resp_addr_d   = '0;
            state_d       = ST_RESP;
          end else begin
            wr_addr_d = free_addr;
            wr_data_d = cmp_data_q;
            wr_del_d  = 1'b0;
            state_d   = ST_ISSUE;
          end
        end else begin
          if (match_q) begin
            wr_addr_d = match_addr_q;
            wr_data_d = cmp_data_q;
            wr_del_d  = 1'b1;
            state_d   = ST_ISSUE;
          end else begin
            resp_status_d = CAM_ST_NOTFOUND;
            resp_addr_d   = '0;
            state_d       = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        wait_first_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        // Busy only rises the cycle after the strobe, so the first WAIT cycle is skipped.
        wait_first_d = 1'b0;
        if (!wait_first_q && !cam_write_busy) begin
          bitmap_d[wr_addr_q] = ~wr_del_q;
          count_d             = wr_del_q ? (count_q - CW'(1)) : (count_q + CW'(1));
          resp_status_d       = CAM_ST_OK;
          resp_addr_d         = wr_addr_q;
          state_d             = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cmp_data_q    <= '0;
      del_q         <= 1'b0;
      lat_cnt_q     <= '0;
      match_q       <= 1'b0;
      match_addr_q  <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_del_q      <= 1'b0;
      wait_first_q  <= 1'b0;
      bitmap_q      <= '0;
      count_q       <= '0;
      resp_addr_q   <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      cmp_data_q    <= cmp_data_d;
      del_q         <= del_d;
      lat_cnt_q     <= lat_cnt_d;
      match_q       <= match_d;
      match_addr_q  <= match_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_del_q      <= wr_del_d;
      wait_first_q  <= wait_first_d;
      bitmap_q      <= bitmap_d;
      count_q       <= count_d;
      resp_addr_q   <= resp_addr_d;
      resp_status_q <= resp_status_d;
    end
  end

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// tb_cam_insert_ctrl
//   Directed bench for cam_insert_ctrl paired with a small behavioural CAM
//   (1-cycle registered compare, 8-cycle init busy, 3-cycle write busy with the
//   write address/data sampled at the end of the busy window).
module tb_cam_insert_ctrl;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] req_data = '0;
  logic          req_delete = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] resp_addr;
  logic [1:0]    resp_status;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [AW:0]   entry_count;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete;
  logic          cam_write_enable;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;

  always #5 clk = ~clk;

  cam_insert_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CMP_LATENCY (1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_data         (req_data),
    .req_delete       (req_delete),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .resp_addr        (resp_addr),
    .resp_status      (resp_status),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .entry_count      (entry_count),
    .cam_write_addr   (cam_write_addr),
    .cam_write_data   (cam_write_data),
    .cam_write_delete (cam_write_delete),
    .cam_write_enable (cam_write_enable),
    .cam_write_busy   (cam_write_busy),
    .cam_compare_data (cam_compare_data),
    .cam_match        (cam_match),
    .cam_match_addr   (cam_match_addr)
  );

  // Behavioural CAM
  logic [DW-1:0] cam_key [N];
  logic [N-1:0]  cam_vld;
  int            init_cnt = 8;
  int            wr_cnt = 0;
  int            we_cnt = 0;

  assign cam_write_busy = (init_cnt != 0) || (wr_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      cam_vld        <= '0;
      init_cnt       <= 8;
      wr_cnt         <= 0;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      if (init_cnt != 0) init_cnt <= init_cnt - 1;
      if (cam_write_enable) begin
        wr_cnt <= 3;
      end else if (wr_cnt == 1) begin
        wr_cnt                  <= 0;
        cam_vld[cam_write_addr] <= ~cam_write_delete;
        cam_key[cam_write_addr] <= cam_write_data;
      end else if (wr_cnt != 0) begin
        wr_cnt <= wr_cnt - 1;
      end
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (cam_vld[i] && (cam_key[i] == cam_compare_data)) begin
          cam_match      <= 1'b1;
          cam_match_addr <= i[AW-1:0];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (cam_write_enable === 1'b1) we_cnt <= we_cnt + 1;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One complete transaction. Entered and left on a falling edge.
  task automatic do_req(input logic [63:0] key, input logic del, input int hold,
                        output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
    int n;
    int bad;
    n = 0;
    while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("req_ready_timeout", {63'd0, req_ready}, 64'd1);
    req_data   = key;
    req_delete = del;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("resp_valid_timeout", {63'd0, resp_valid}, 64'd1);
    lat = n;
    st  = resp_status;
    ad  = resp_addr;
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_status !== st || resp_addr !== ad || req_ready !== 1'b0)
        bad++;
    end
    if (hold > 0) check("resp_hold_stable", bad, 0);
    $display("req key=0x%0h del=%0d -> status=%0d addr=%0d count=%0d lat=%0d",
             key, del, st, ad, entry_count, lat);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]    st;
    logic [AW-1:0] ad;
    int            lat;
    int            w0;
    int            n;

    // Reset and CAM init
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_count", entry_count, 0);
    check("rst_we", cam_write_enable, 0);
    rst = 1'b0;
    @(negedge clk);
    check("init_req_ready_low", req_ready, 0);

    // First insert
    w0 = we_cnt;
    do_req(64'h1234, 1'b0, 0, st, ad, lat);
    check("ins1_status", st, 0);
    check("ins1_addr", ad, 0);
    check("ins1_count", entry_count, 1);
    check("ins1_we_pulses", we_cnt - w0, 1);

    // Duplicate insert
    w0 = we_cnt;
    do_req(64'h1234, 1'b0, 0, st, ad, lat);
    check("dup_status", st, 1);
    check("dup_addr", ad, 0);
    check("dup_count", entry_count, 1);
    check("dup_we_pulses", we_cnt - w0, 0);
    check("dup_latency", lat, 3);

    // Fill remaining entries
    for (int i = 1; i < N; i++) begin
      do_req(64'h1000 + 64'(i), 1'b0, 0, st, ad, lat);
      check("fill_status", st, 0);
      check("fill_addr", ad, 64'(i));
    end
    check("fill_count", entry_count, 32);

    // Insert into full table
    w0 = we_cnt;
    do_req(64'hDEAD, 1'b0, 0, st, ad, lat);
    check("full_status", st, 2);
    check("full_addr", ad, 0);
    check("full_count", entry_count, 32);
    check("full_we_pulses", we_cnt - w0, 0);

    // Delete addr 5 then reuse it
    do_req(64'h1005, 1'b1, 0, st, ad, lat);
    check("del5_status", st, 0);
    check("del5_addr", ad, 5);
    check("del5_count", entry_count, 31);
    do_req(64'hBEEF, 1'b0, 0, st, ad, lat);
    check("reuse_status", st, 0);
    check("reuse_addr", ad, 5);
    check("reuse_count", entry_count, 32);

    // Delete absent key with a stalled consumer
    w0 = we_cnt;
    do_req(64'hFFFF, 1'b1, 10, st, ad, lat);
    check("nf_status", st, 3);
    check("nf_addr", ad, 0);
    check("nf_we_pulses", we_cnt - w0, 0);
    check("nf_latency", lat, 3);

    // Free addr 7, then reset while the insert is waiting on the CAM
    do_req(64'h1007, 1'b1, 0, st, ad, lat);
    check("del7_addr", ad, 7);
    check("del7_count", entry_count, 31);
    n = 0;
    while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("req_ready_timeout", {63'd0, req_ready}, 64'd1);
    req_data   = 64'h5555;
    req_delete = 1'b0;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (cam_write_enable !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("issue_seen", cam_write_enable, 1);
    check("issue_addr", cam_write_addr, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_count", entry_count, 0);
    check("midrst_req_ready", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    do_req(64'h1234, 1'b1, 0, st, ad, lat);
    check("postrst_del_status", st, 3);
    check("postrst_del_count", entry_count, 0);
    do_req(64'h42, 1'b0, 0, st, ad, lat);
    check("postrst_ins_status", st, 0);
    check("postrst_ins_addr", ad, 0);
    check("postrst_ins_count", entry_count, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
